// File: rtl/sha_work_loader.sv
// sha_work_loader
//   Upstream feeder for the SHA solver. A 96-byte work packet (32-byte
//   midstate followed by a 64-byte header block) arrives as a byte stream and
//   is assembled in a shadow register. When the last byte lands, the packet
//   is committed to midState/headData and the solver is sequenced: loadState
//   is held low for CLR_CYCLES to clear its counters, then loadState/solveEn
//   go high. The solver's flag/goldenNonce is watched, ignoring the first
//   FLAG_HOLDOFF solve cycles, and each solved job yields one job_done pulse.
//   A new packet may stream in while a job is solving.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   rx_data/valid   byte stream; byte accepted when rx_valid & rx_ready
//   rx_sof          accepted byte is packet byte 0 (restarts the fill)
//   rx_ready        high except while clearing the solver
//   midState        committed 256-bit midstate to the solver
//   headData        committed 512-bit header block to the solver
//   loadState       high = solver counters run, low = counters cleared
//   solveEn         solver enable
//   flag            solver found-nonce level, goldenNonce valid with it
//   job_done        1-cycle pulse when a solved nonce is captured
//   result_nonce    nonce captured at the last job_done
//   job_timeout     1-cycle pulse when the solve budget expires
//                   (only with SHA_LOADER_TIMEOUT_EN)
//   busy            state is not IDLE
//
// Configuration macro
//   SHA_LOADER_TIMEOUT_EN : adds the TIMEOUT_CYCLES solve budget and the
//                           job_timeout output.

module sha_work_loader #(
    parameter int CLR_CYCLES   = 2,
    parameter int FLAG_HOLDOFF = 2
`ifdef SHA_LOADER_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFFFFF
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         rx_sof,
    output logic         rx_ready,
    output logic [255:0] midState,
    output logic [511:0] headData,
    output logic         loadState,
    output logic         solveEn,
    input  logic         flag,
    input  logic [31:0]  goldenNonce,
    output logic         job_done,
    output logic [31:0]  result_nonce,
`ifdef SHA_LOADER_TIMEOUT_EN
    output logic         job_timeout,
`endif
    output logic         busy
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int HO_W  = $clog2(FLAG_HOLDOFF + 2);

    typedef enum logic [1:0] {IDLE, CLEAR, SOLVE} state_t;

    state_t            state;
    logic [6:0]        byte_cnt;
    logic [767:0]      shadow;
    logic [767:0]      shadow_nxt;
    logic [CLR_W-1:0]  clr_cnt;
    logic [HO_W-1:0]   ho_cnt;
    logic              ho_done;
    logic              accept;
    logic              commit;
    logic [6:0]        wr_idx;
    logic [9:0]        bit_hi;
`ifdef SHA_LOADER_TIMEOUT_EN
    logic [31:0]       to_cnt;
`endif

    assign rx_ready = (state != CLEAR);
    assign busy     = (state != IDLE);
    assign ho_done  = (ho_cnt == HO_W'(FLAG_HOLDOFF));

    // Byte placement: the whole packet lives in one 768-bit shadow with byte
    // k at [767-8k -: 8], which makes midstate the top 256 bits and the header
    // the bottom 512, both MSB first. sof forces the write slot back to 0 no
    // matter where the previous fill had got to, so a stale partial packet is
    // simply overwritten. shadow_nxt already contains the incoming byte, which
    // lets the commit edge capture byte 95 directly.
    always_comb begin
        accept     = rx_valid & rx_ready;
        wr_idx     = rx_sof ? 7'd0 : byte_cnt;
        commit     = accept && (wr_idx == 7'd95);
        bit_hi     = 10'd767 - {wr_idx, 3'b000};
        shadow_nxt = shadow;
        if (accept) begin
            shadow_nxt[bit_hi -: 8] = rx_data;
        end
    end

    // Fill counter, commit and job sequencing. In SOLVE a valid flag and a
    // commit may land on the same edge: the old job's nonce is captured and
    // reported, and the new packet still moves the solver into CLEAR, so no
    // result is ever dropped. The hold-off counter saturates at FLAG_HOLDOFF
    // so the solver's stale flag from the previous job cannot end a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            shadow       <= '0;
            midState     <= '0;
            headData     <= '0;
            loadState    <= 1'b0;
            solveEn      <= 1'b0;
            job_done     <= 1'b0;
            result_nonce <= '0;
            clr_cnt      <= '0;
            ho_cnt       <= '0;
`ifdef SHA_LOADER_TIMEOUT_EN
            job_timeout  <= 1'b0;
            to_cnt       <= '0;
`endif
        end else begin
            job_done <= 1'b0;
`ifdef SHA_LOADER_TIMEOUT_EN
            job_timeout <= 1'b0;
`endif
            shadow <= shadow_nxt;
            if (commit) begin
                byte_cnt <= '0;
                midState <= shadow_nxt[767:512];
                headData <= shadow_nxt[511:0];
            end else if (accept) begin
                byte_cnt <= wr_idx + 7'd1;
            end

            case (state)
                IDLE: begin
                    loadState <= 1'b0;
                    solveEn   <= 1'b0;
                    if (commit) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        state     <= SOLVE;
                        loadState <= 1'b1;
                        solveEn   <= 1'b1;
                        ho_cnt    <= '0;
`ifdef SHA_LOADER_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                SOLVE: begin
                    if (flag && ho_done) begin
                        result_nonce <= goldenNonce;
                        job_done     <= 1'b1;
                    end
                    if (commit) begin
                        state     <= CLEAR;
                        clr_cnt   <= '0;
                        loadState <= 1'b0;
                        solveEn   <= 1'b0;
                    end else if (flag && ho_done) begin
                        state     <= IDLE;
                        loadState <= 1'b0;
                        solveEn   <= 1'b0;
`ifdef SHA_LOADER_TIMEOUT_EN
                    end else if (to_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        state       <= IDLE;
                        loadState   <= 1'b0;
                        solveEn     <= 1'b0;
                        job_timeout <= 1'b1;
`endif
                    end else begin
                        if (!ho_done) begin
                            ho_cnt <= ho_cnt + HO_W'(1);
                        end
`ifdef SHA_LOADER_TIMEOUT_EN
                        to_cnt <= to_cnt + 32'd1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    loadState <= 1'b0;
                    solveEn   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_work_loader.sv
// tb_sha_work_loader
//   Directed bench for sha_work_loader: reset values, packet fill and commit,
//   flag hold-off and capture, sof restart, streaming during a solve with a
//   simultaneous flag/commit, reset mid-packet and mid-solve, and (with
//   SHA_LOADER_TIMEOUT_EN) the solve timeout.

module tb_sha_work_loader;

`ifdef SHA_LOADER_TIMEOUT_EN
    localparam bit TimeoutBuild = 1'b1;
`else
    localparam bit TimeoutBuild = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_sof;
    logic         rx_ready;
    logic [255:0] midState;
    logic [511:0] headData;
    logic         loadState;
    logic         solveEn;
    logic         flag;
    logic [31:0]  goldenNonce;
    logic         job_done;
    logic [31:0]  result_nonce;
    logic         busy;
`ifdef SHA_LOADER_TIMEOUT_EN
    logic         job_timeout;
`endif

    int nCompared;
    int nMismatched;

    logic [7:0]   pkt [96];
    logic [767:0] img;

    typedef struct {
        logic        flag;
        logic [31:0] gnonce;
        logic        expLoad;
        logic        expSolve;
        logic        expDone;
        logic [31:0] expNonce;
        logic        expReady;
        logic        expBusy;
    } vec_t;

    vec_t vecs [10];

`ifdef SHA_LOADER_TIMEOUT_EN
    sha_work_loader #(.CLR_CYCLES(2), .FLAG_HOLDOFF(2), .TIMEOUT_CYCLES(32'd10)) dut (
`else
    sha_work_loader #(.CLR_CYCLES(2), .FLAG_HOLDOFF(2)) dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_ready     (rx_ready),
        .midState     (midState),
        .headData     (headData),
        .loadState    (loadState),
        .solveEn      (solveEn),
        .flag         (flag),
        .goldenNonce  (goldenNonce),
        .job_done     (job_done),
        .result_nonce (result_nonce),
`ifdef SHA_LOADER_TIMEOUT_EN
        .job_timeout  (job_timeout),
`endif
        .busy         (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs at the falling edge, let the rising edge
    // act on them, and return at the next falling edge for sampling.
    task automatic applyStimulus(input logic r, input logic v, input logic s,
                                 input logic [7:0] d, input logic f,
                                 input logic [31:0] gn);
        rst         = r;
        rx_valid    = v;
        rx_sof      = s;
        rx_data     = d;
        flag        = f;
        goldenNonce = gn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkWide(input string name, input logic [767:0] act,
                             input logic [767:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected committed image from the packet bytes: byte k at [767-8k -: 8].
    function automatic logic [767:0] buildImage();
        logic [767:0] r;
        r = '0;
        for (int k = 0; k < 96; k++) begin
            r[767 - 8*k -: 8] = pkt[k];
        end
        return r;
    endfunction

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    initial begin
        int early;

        nCompared   = 0;
        nMismatched = 0;

        // Cycle-by-cycle expectations right after the first commit edge:
        // two CLEAR edges, SOLVE entry, a flag inside hold-off (cycle 1),
        // the real flag on solve cycle 5, then flag held high in IDLE.
        vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};

        // Reset values
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        checkWide("rst_image", {midState, headData}, 768'h0);
        checkOutput("rst_loadState", 32'(loadState), 32'd0);
        checkOutput("rst_solveEn", 32'(solveEn), 32'd0);
        checkOutput("rst_job_done", 32'(job_done), 32'd0);
        checkOutput("rst_result", result_nonce, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        idleCycle();
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);

        // Packet 0x00..0x5F, commit on byte 95
        for (int k = 0; k < 96; k++) begin
            pkt[k] = 8'(k);
            applyStimulus(1'b0, 1'b1, k == 0, pkt[k], 1'b0, 32'h0);
        end
        img = buildImage();
        checkOutput("t1_mid_top", 32'(midState[255:248]), 32'h00);
        checkOutput("t1_head_low", 32'(headData[7:0]), 32'h5F);
        checkWide("t1_image", {midState, headData}, img);
        checkOutput("t1_commit_loadState", 32'(loadState), 32'd0);
        checkOutput("t1_commit_busy", 32'(busy), 32'd1);
        checkOutput("t1_commit_rx_ready", 32'(rx_ready), 32'd0);

        // Table: CLEAR length, hold-off, capture, flag ignored in IDLE
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, vecs[i].flag, vecs[i].gnonce);
            checkOutput($sformatf("vec%0d_loadState", i), 32'(loadState), 32'(vecs[i].expLoad));
            checkOutput($sformatf("vec%0d_solveEn", i), 32'(solveEn), 32'(vecs[i].expSolve));
            checkOutput($sformatf("vec%0d_job_done", i), 32'(job_done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d_result", i), result_nonce, vecs[i].expNonce);
            checkOutput($sformatf("vec%0d_rx_ready", i), 32'(rx_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
        end

        // Partial packet then sof restart: exactly one commit, all 0xA5
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 1'b1, k == 0, 8'h11, 1'b0, 32'h0);
        end
        checkWide("t3_partial_hidden", {midState, headData}, img);
        checkOutput("t3_partial_busy", 32'(busy), 32'd0);
        early = 0;
        for (int k = 0; k < 96; k++) begin
            pkt[k] = 8'hA5;
            applyStimulus(1'b0, 1'b1, k == 0, 8'hA5, 1'b0, 32'h0);
            if (k < 95 && busy) early++;
        end
        img = buildImage();
        checkOutput("t3_early_commits", 32'(early), 32'd0);
        checkOutput("t3_commit_busy", 32'(busy), 32'd1);
        checkWide("t3_image", {midState, headData}, img);
        idleCycle();
        idleCycle();
        checkOutput("t3_solve_loadState", 32'(loadState), 32'd1);
        checkOutput("t3_solve_solveEn", 32'(solveEn), 32'd1);

        // Packet B streamed during SOLVE of A, flag on the same edge as byte 95
        early = 0;
        for (int k = 0; k < 96; k++) begin
            pkt[k] = 8'(255 - k);
            applyStimulus(1'b0, 1'b1, k == 0, pkt[k], k == 95,
                          (k == 95) ? 32'hCAFEF00D : 32'h0);
            if (k < 95 && (job_done || (solveEn != (!TimeoutBuild || k < 9)))) early++;
        end
        img = buildImage();
        checkOutput("t4_stream_solve", 32'(early), 32'd0);
        checkOutput("t4_job_done", 32'(job_done), TimeoutBuild ? 32'd0 : 32'd1);
        checkOutput("t4_result", result_nonce, TimeoutBuild ? 32'hDEADBEEF : 32'hCAFEF00D);
        checkWide("t4_image", {midState, headData}, img);
        checkOutput("t4_clear_loadState", 32'(loadState), 32'd0);
        checkOutput("t4_clear_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("t4_clear_busy", 32'(busy), 32'd1);
        idleCycle();
        checkOutput("t4_pulse_end", 32'(job_done), 32'd0);
        checkOutput("t4_clear2_loadState", 32'(loadState), 32'd0);
        idleCycle();
        checkOutput("t4_solve_loadState", 32'(loadState), 32'd1);
        checkOutput("t4_solve_solveEn", 32'(solveEn), 32'd1);

        // Reset at byte 50 of a packet
        for (int k = 0; k < 50; k++) begin
            applyStimulus(1'b0, 1'b1, k == 0, 8'h33, 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        checkWide("t5a_image", {midState, headData}, 768'h0);
        checkOutput("t5a_loadState", 32'(loadState), 32'd0);
        checkOutput("t5a_solveEn", 32'(solveEn), 32'd0);
        checkOutput("t5a_job_done", 32'(job_done), 32'd0);
        checkOutput("t5a_result", result_nonce, 32'h0);
        checkOutput("t5a_busy", 32'(busy), 32'd0);
        idleCycle();
        checkOutput("t5a_rx_ready", 32'(rx_ready), 32'd1);

        // Next packet without sof must still start at byte 0
        early = 0;
        for (int k = 0; k < 96; k++) begin
            pkt[k] = 8'(k + 128);
            applyStimulus(1'b0, 1'b1, 1'b0, pkt[k], 1'b0, 32'h0);
            if (k < 95 && busy) early++;
        end
        img = buildImage();
        checkOutput("t5_early_commits", 32'(early), 32'd0);
        checkWide("t5_image", {midState, headData}, img);
        idleCycle();
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("t5b_pre_solveEn", 32'(solveEn), 32'd1);

        // Reset mid-SOLVE with flag high: everything cleared, no job_done
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0BADF00D);
        checkWide("t5b_image", {midState, headData}, 768'h0);
        checkOutput("t5b_loadState", 32'(loadState), 32'd0);
        checkOutput("t5b_solveEn", 32'(solveEn), 32'd0);
        checkOutput("t5b_job_done", 32'(job_done), 32'd0);
        checkOutput("t5b_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0BADF00D);
        checkOutput("t5b_idle_flag_done", 32'(job_done), 32'd0);
        checkOutput("t5b_idle_flag_result", result_nonce, 32'h0);

`ifdef SHA_LOADER_TIMEOUT_EN
        // Solve budget of 10 cycles with flag never set
        for (int k = 0; k < 96; k++) begin
            applyStimulus(1'b0, 1'b1, k == 0, 8'h5A, 1'b0, 32'h0);
        end
        idleCycle();
        idleCycle();
        for (int i = 1; i <= 11; i++) begin
            idleCycle();
            checkOutput($sformatf("t6_timeout_c%0d", i), 32'(job_timeout),
                        (i == 10) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t6_busy_c%0d", i), 32'(busy),
                        (i < 10) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t6_done_c%0d", i), 32'(job_done), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
